// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator request scheduler.
package elevator_pkg;
  localparam int FLOOR_W            = 4;
  localparam int DEFAULT_NUM_FLOORS = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DWELL
  } sched_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/elevator_request_sync.sv
// Call-button front end: rising-edge detector, plus (under SCHED_DEBOUNCE_EN)
// a two-flop synchronizer and a 4-cycle stability filter ahead of it.
module request_sync
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_edge,
  output logic [FLOOR_W-1:0] edge_floor
);

  logic level;
  logic level_prev_reg;

`ifdef SCHED_DEBOUNCE_EN
  localparam logic [2:0] STABLE_COUNT = 3'd4;

  logic               valid_meta_reg, valid_sync_reg;
  logic [FLOOR_W-1:0] floor_meta_reg, floor_sync_reg, floor_hold_reg;
  logic [2:0]         stable_cnt_reg;

  // A changing floor code restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_meta_reg <= 1'b0;
      valid_sync_reg <= 1'b0;
      floor_meta_reg <= '0;
      floor_sync_reg <= '0;
      floor_hold_reg <= '0;
      stable_cnt_reg <= '0;
    end else begin
      valid_meta_reg <= req_valid;
      valid_sync_reg <= valid_meta_reg;
      floor_meta_reg <= req_floor;
      floor_sync_reg <= floor_meta_reg;
      floor_hold_reg <= floor_sync_reg;
      if (!valid_sync_reg)
        stable_cnt_reg <= '0;
      else if (floor_sync_reg != floor_hold_reg)
        stable_cnt_reg <= 3'd1;
      else if (stable_cnt_reg != STABLE_COUNT)
        stable_cnt_reg <= stable_cnt_reg + 3'd1;
    end
  end

  assign level      = (stable_cnt_reg == STABLE_COUNT);
  assign edge_floor = floor_hold_reg;
`else
  assign level      = req_valid;
  assign edge_floor = req_floor;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      level_prev_reg <= 1'b0;
    else
      level_prev_reg <= level;
  end

  assign req_edge = level & ~level_prev_reg;

endmodule

// File: rtl/elevator_request_scheduler.sv
// Pending-request bitmap with SCAN target selection for the elevator FSM.
// Optional input debouncing is enabled with the SCHED_DEBOUNCE_EN macro.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEFAULT_NUM_FLOORS,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);

  localparam logic [31:0] DWELL_LOAD = (DWELL_CYCLES < 1) ? 32'd1 : 32'(DWELL_CYCLES);

  sched_state_t          state_reg, state_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic [FLOOR_W-1:0]    requested_floor_reg, requested_floor_next;
  logic                  dir_up_reg, dir_up_next;
  logic [31:0]           dwell_cnt_reg, dwell_cnt_next;
  logic                  busy_reg;

  logic                  req_edge;
  logic [FLOOR_W-1:0]    edge_floor;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask, cur_onehot, above_mask, below_mask;
  logic                  above_found, below_found;
  logic [FLOOR_W-1:0]    above_idx, below_idx;
  logic                  cur_valid;

  request_sync u_request_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_floor  (req_floor),
    .req_edge   (req_edge),
    .edge_floor (edge_floor)
  );

  assign cur_valid = (int'(current_floor) < NUM_FLOORS);

  // Out-of-range floor codes match no bit, so they are dropped here.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign set_mask[gi]   = req_edge && (int'(edge_floor) == gi);
      assign cur_onehot[gi] = (int'(current_floor) == gi);
      assign above_mask[gi] = pending_reg[gi] && (gi > int'(current_floor));
      assign below_mask[gi] = pending_reg[gi] && (gi < int'(current_floor));
    end
  endgenerate

  // Nearest pending floor above (lowest index) and below (highest index).
  always_comb begin
    above_found = 1'b0;
    above_idx   = '0;
    below_found = 1'b0;
    below_idx   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above_mask[i]) begin
        above_found = 1'b1;
        above_idx   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below_mask[i]) begin
        below_found = 1'b1;
        below_idx   = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    state_next           = state_reg;
    requested_floor_next = requested_floor_reg;
    dir_up_next          = dir_up_reg;
    dwell_cnt_next       = dwell_cnt_reg;
    clr_mask             = '0;
    case (state_reg)
      S_IDLE: begin
        if (car_idle && (|pending_reg) && cur_valid) begin
          if (|(pending_reg & cur_onehot)) begin
            clr_mask             = cur_onehot;
            requested_floor_next = current_floor;
            dwell_cnt_next       = DWELL_LOAD;
            state_next           = S_DWELL;
          end else if (dir_up_reg == DIR_UP) begin
            if (above_found) begin
              requested_floor_next = above_idx;
              state_next           = S_UP;
            end else begin
              requested_floor_next = below_idx;
              dir_up_next          = DIR_DOWN;
              state_next           = S_DOWN;
            end
          end else begin
            if (below_found) begin
              requested_floor_next = below_idx;
              state_next           = S_DOWN;
            end else begin
              requested_floor_next = above_idx;
              dir_up_next          = DIR_UP;
              state_next           = S_UP;
            end
          end
        end
      end
      S_UP, S_DOWN: begin
        if (car_idle && (current_floor == requested_floor_reg)) begin
          clr_mask       = cur_onehot;
          dwell_cnt_next = DWELL_LOAD;
          state_next     = S_DWELL;
        end
      end
      S_DWELL: begin
        // Calls for the floor the doors are open at are absorbed.
        clr_mask = cur_onehot;
        if (dwell_cnt_reg <= 32'd1) begin
          dwell_cnt_next = '0;
          state_next     = S_IDLE;
        end else begin
          dwell_cnt_next = dwell_cnt_reg - 32'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    pending_next = (pending_reg | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg           <= S_IDLE;
      pending_reg         <= '0;
      requested_floor_reg <= '0;
      dir_up_reg          <= DIR_UP;
      dwell_cnt_reg       <= '0;
      busy_reg            <= 1'b0;
    end else begin
      state_reg           <= state_next;
      pending_reg         <= pending_next;
      requested_floor_reg <= requested_floor_next;
      dir_up_reg          <= dir_up_next;
      dwell_cnt_reg       <= dwell_cnt_next;
      busy_reg            <= (|pending_reg) || (state_reg != S_IDLE);
    end
  end

  assign requested_floor = requested_floor_reg;
  assign pending         = pending_reg;
  assign dir_up          = dir_up_reg;
  assign busy            = busy_reg;

endmodule
